eim_da_responder: RTL and testbench

- Protocol engine for the EIM multiplexed address/data (DA) port; the FPGA acts as bus responder to the i.MX initiator.
- Sits between the DA pad buffer (drives its drive-input and tristate control, reads its receiver output) and the internal system bus.
- Decodes the address phase and 2-beat 32-bit write/read phases, issues a single request/ack transaction on the system side, and stalls the initiator with wait while that transaction is outstanding.

---
 rtl/eim_da_pkg.sv | 27 ++
 rtl/eim_da_responder_if.sv | 37 +++
 rtl/eim_da_wdog.sv | 25 ++
 rtl/eim_da_responder.sv | 126 ++++++++++++
 tb/tb_eim_da_responder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eim_da_pkg.sv
// Shared definitions for the EIM multiplexed address/data responder.
// State encoding, word widths and the timeout fill pattern.
package eim_da_pkg;

  localparam int DA_BUS_WIDTH  = 16;
  localparam int DA_WORD_WIDTH = 2 * DA_BUS_WIDTH;

  // Returned on the pins when a read times out.
  localparam logic [31:0] EIM_DA_DEAD_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_HI,
    WR_REQ,
    RD_REQ,
    RD_LO,
    RD_HI,
    DONE
  } da_state_e;

  // True while a system-side request is outstanding.
  function automatic logic is_req(da_state_e s);
    return (s == WR_REQ) || (s == RD_REQ);
  endfunction

endpackage

// File: rtl/eim_da_responder_if.sv
// EIM DA pin-side and system-bus-side signal bundle.
// slave: the responder; master: whatever drives the EIM pins and serves the bus.
interface eim_da_responder_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                   eim_cs_n;
  logic                   eim_lba_n;
  logic                   eim_wr_n;
  logic                   eim_oe_n;
  logic                   eim_beat;
  logic [BUS_WIDTH-1:0]   da_ro;
  logic [BUS_WIDTH-1:0]   da_di;
  logic                   da_t;
  logic                   eim_wait_n;
  logic [ADDR_WIDTH-1:0]  sys_addr;
  logic                   sys_wr;
  logic                   sys_rd;
  logic [2*BUS_WIDTH-1:0] sys_wdata;
  logic [2*BUS_WIDTH-1:0] sys_rdata;
  logic                   sys_ack;
  logic                   sys_err;

  modport slave (
    input  eim_cs_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_beat, da_ro,
    input  sys_rdata, sys_ack,
    output da_di, da_t, eim_wait_n,
    output sys_addr, sys_wr, sys_rd, sys_wdata, sys_err
  );

  modport master (
    output eim_cs_n, eim_lba_n, eim_wr_n, eim_oe_n, eim_beat, da_ro,
    output sys_rdata, sys_ack,
    input  da_di, da_t, eim_wait_n,
    input  sys_addr, sys_wr, sys_rd, sys_wdata, sys_err
  );
endinterface

// File: rtl/eim_da_wdog.sv
// Loadable down-counter: reloads while load is high, counts while en is high,
// and flags expire in the CYCLES-th consecutive enabled cycle.
module eim_da_wdog #(
  parameter int CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] INIT = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Reload outside a request, count down while one is outstanding.
  always_ff @(posedge clk) begin
    if (rst)                      cnt <= INIT;
    else if (load)                cnt <= INIT;
    else if (en && cnt != '0)     cnt <= cnt - CW'(1);
  end

  assign expire = en & (cnt == '0);
endmodule

// File: rtl/eim_da_responder.sv
// EIM multiplexed address/data responder: decodes the address beat and the
// two 16-bit data beats, issues one request/ack on the system side and holds
// eim_wait_n low while it is outstanding.
// Optional: EIM_DA_TIMEOUT_EN adds a request watchdog (TIMEOUT_CYCLES) that
// pulses sys_err and completes a stalled read with the dead word.
module eim_da_responder
  import eim_da_pkg::*;
#(
  parameter int BUS_WIDTH      = DA_BUS_WIDTH,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  eim_da_responder_if.slave bus
);
  localparam int WW = 2 * BUS_WIDTH;

  da_state_e             state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WW-1:0]         wdata_q;
  logic [WW-1:0]         hold_q;
  logic [WW-1:0]         hold_src;
  logic                  addr_ld, wlo_ld, whi_ld, hold_ld;
  logic                  in_req;
  logic                  to_hit;

  assign in_req = is_req(state);

`ifdef EIM_DA_TIMEOUT_EN
  localparam logic [WW-1:0] DEAD = WW'(EIM_DA_DEAD_WORD);
  logic wd_expire;

  eim_da_wdog #(.CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .load   (~in_req),
    .en     (in_req),
    .expire (wd_expire)
  );

  // An ack in the expiry cycle wins; an abort suppresses the error.
  assign to_hit      = wd_expire & ~bus.sys_ack & ~bus.eim_cs_n;
  assign hold_src    = bus.sys_ack ? bus.sys_rdata : DEAD;
  assign bus.sys_err = to_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
  assign hold_src       = bus.sys_rdata;
  assign bus.sys_err    = 1'b0;
`endif

  // Next-state and datapath load enables; chip-select release aborts everything.
  always_comb begin
    state_nx = state;
    addr_ld  = 1'b0;
    wlo_ld   = 1'b0;
    whi_ld   = 1'b0;
    hold_ld  = 1'b0;
    if (bus.eim_cs_n) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.eim_beat && !bus.eim_lba_n) begin
          state_nx = ADDR;
          addr_ld  = 1'b1;
        end
        ADDR: if (bus.eim_beat && bus.eim_lba_n) begin
          if (!bus.eim_wr_n) begin
            state_nx = WR_HI;
            wlo_ld   = 1'b1;
          end else if (!bus.eim_oe_n) begin
            state_nx = RD_REQ;
          end
        end
        WR_HI: if (bus.eim_beat) begin
          state_nx = WR_REQ;
          whi_ld   = 1'b1;
        end
        WR_REQ: if (bus.sys_ack || to_hit) state_nx = DONE;
        RD_REQ: if (bus.sys_ack || to_hit) begin
          state_nx = RD_LO;
          hold_ld  = 1'b1;
        end
        RD_LO:   if (bus.eim_beat) state_nx = RD_HI;
        RD_HI:   if (bus.eim_beat) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  // Address, write-data and read-hold registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      if (addr_ld) addr_q                   <= bus.da_ro[ADDR_WIDTH-1:0];
      if (wlo_ld)  wdata_q[BUS_WIDTH-1:0]   <= bus.da_ro;
      if (whi_ld)  wdata_q[WW-1:BUS_WIDTH]  <= bus.da_ro;
      if (hold_ld) hold_q                   <= hold_src;
    end
  end

  assign bus.sys_addr   = addr_q;
  assign bus.sys_wdata  = wdata_q;
  assign bus.sys_wr     = (state == WR_REQ);
  assign bus.sys_rd     = (state == RD_REQ);
  assign bus.eim_wait_n = ~in_req;

  assign bus.da_di = (state == RD_LO) ? hold_q[BUS_WIDTH-1:0]  :
                     (state == RD_HI) ? hold_q[WW-1:BUS_WIDTH] : '0;

  // Drive the pins only when the initiator is reading and still selected.
  assign bus.da_t = ~(((state == RD_LO) || (state == RD_HI)) &&
                      !bus.eim_oe_n && !bus.eim_cs_n);
endmodule

// File: tb/tb_eim_da_responder.sv
// Scoreboard bench for eim_da_responder: stimulus pushes expected system
// requests, error pulses and pin words; a negedge monitor pops and compares.
module tb_eim_da_responder;
  typedef enum int {EV_WR, EV_RD, EV_PIN, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] addr;
    logic [31:0] data;
    int          len;
  } ev_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  ev_t  sb[$];

  eim_da_responder_if #(.BUS_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  eim_da_responder #(
    .BUS_WIDTH      (16),
    .ADDR_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [15:0] a, input logic [31:0] d, input int len);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.len = len;
    sb.push_back(e);
  endtask

  task automatic pop(input string name, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = EV_ERR; e.addr = '0; e.data = '0; e.len = 0;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected event, scoreboard empty", name);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic beat, input logic cs_n, input logic lba_n,
                      input logic wr_n, input logic oe_n, input logic [15:0] da);
    bus.eim_beat  = beat;
    bus.eim_cs_n  = cs_n;
    bus.eim_lba_n = lba_n;
    bus.eim_wr_n  = wr_n;
    bus.eim_oe_n  = oe_n;
    bus.da_ro     = da;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_da_t"},   32'(bus.da_t),       32'd1);
    chk({tag, "_da_di"},  32'(bus.da_di),      32'd0);
    chk({tag, "_wait_n"}, 32'(bus.eim_wait_n), 32'd1);
    chk({tag, "_wr"},     32'(bus.sys_wr),     32'd0);
    chk({tag, "_rd"},     32'(bus.sys_rd),     32'd0);
    chk({tag, "_addr"},   32'(bus.sys_addr),   32'd0);
    chk({tag, "_wdata"},  bus.sys_wdata,       32'd0);
    chk({tag, "_err"},    32'(bus.sys_err),    32'd0);
  endtask

  // Monitor state
  logic        prev_t  = 1'b1;
  logic [15:0] prev_di = '0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  int          run_len = 0;
  int          exp_len = 0;

  // Monitor: pop and compare whenever the DUT presents a request, error or pin word.
  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      chk("wait_n", 32'(bus.eim_wait_n), 32'(!(bus.sys_wr || bus.sys_rd)));
      if ((bus.sys_wr && !prev_wr) || (bus.sys_rd && !prev_rd)) begin
        pop("req", e, ok);
        if (ok) begin
          chk("req_kind", 32'(bus.sys_wr ? EV_WR : EV_RD), 32'(e.kind));
          chk("req_addr", 32'(bus.sys_addr), 32'(e.addr));
          if (bus.sys_wr) chk("req_wdata", bus.sys_wdata, e.data);
          exp_len = e.len;
        end
        run_len = 0;
      end
      if (bus.sys_wr || bus.sys_rd) run_len++;
      else if (prev_wr || prev_rd) chk("req_len", 32'(run_len), 32'(exp_len));
      if (bus.sys_err) begin
        pop("err", e, ok);
        if (ok) chk("err_kind", 32'(EV_ERR), 32'(e.kind));
      end
      if (!bus.da_t && (prev_t || bus.da_di != prev_di)) begin
        pop("pin", e, ok);
        if (ok) begin
          chk("pin_kind", 32'(EV_PIN), 32'(e.kind));
          chk("pin_data", 32'(bus.da_di), e.data);
        end
      end
      prev_t  = bus.da_t;
      prev_di = bus.da_di;
      prev_wr = bus.sys_wr;
      prev_rd = bus.sys_rd;
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.eim_cs_n = 1'b1; bus.eim_lba_n = 1'b1; bus.eim_wr_n = 1'b1;
    bus.eim_oe_n = 1'b1; bus.eim_beat = 1'b0;  bus.da_ro = '0;
    bus.sys_ack  = 1'b0; bus.sys_rdata = '0;
    rst = 1'b1;
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // Write 0x12345678 to 0x0042, ack in the third request cycle
    push(EV_WR, 16'h0042, 32'h12345678, 3);
    step(1, 0, 0, 1, 1, 16'h0042);
    step(1, 0, 1, 0, 1, 16'h5678);
    step(1, 0, 1, 0, 1, 16'h1234);
    step(0, 0, 1, 1, 1, 16'h0);
    step(0, 0, 1, 1, 1, 16'h0);
    bus.sys_ack = 1'b1;
    step(0, 0, 1, 1, 1, 16'h0);
    bus.sys_ack = 1'b0;
    chk("wr_addr_hold", 32'(bus.sys_addr), 32'h0042);
    step(0, 1, 1, 1, 1, 16'h0);

    // Read 0xCAFEF00D from 0x0010, ack in the second request cycle
    push(EV_RD, 16'h0010, 32'h0, 2);
    step(1, 0, 0, 1, 1, 16'h0010);
    step(1, 0, 1, 1, 0, 16'h0);
    step(0, 0, 1, 1, 0, 16'h0);
    push(EV_PIN, 16'h0, 32'h0000F00D, 0);
    push(EV_PIN, 16'h0, 32'h0000CAFE, 0);
    bus.sys_ack = 1'b1; bus.sys_rdata = 32'hCAFEF00D;
    step(0, 0, 1, 1, 0, 16'h0);
    bus.sys_ack = 1'b0;
    step(0, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    chk("rd_done_da_t", 32'(bus.da_t), 32'd1);
    step(0, 1, 1, 1, 1, 16'h0);

    // Abort during RD_REQ, then a late ack that must be ignored
    push(EV_RD, 16'h0020, 32'h0, 2);
    step(1, 0, 0, 1, 1, 16'h0020);
    step(1, 0, 1, 1, 0, 16'h0);
    step(0, 0, 1, 1, 0, 16'h0);
    step(0, 1, 1, 1, 1, 16'h0);
    chk("abort_rd", 32'(bus.sys_rd), 32'd0);
    chk("abort_da_t", 32'(bus.da_t), 32'd1);
    bus.sys_ack = 1'b1; bus.sys_rdata = 32'h11112222;
    step(0, 1, 1, 1, 1, 16'h0);
    bus.sys_ack = 1'b0;
    step(0, 1, 1, 1, 1, 16'h0);

    // Next transaction decodes normally; ack in the first request cycle
    push(EV_WR, 16'h0033, 32'hABCD0001, 1);
    step(1, 0, 0, 1, 1, 16'h0033);
    step(1, 0, 1, 0, 1, 16'h0001);
    step(1, 0, 1, 0, 1, 16'hABCD);
    bus.sys_ack = 1'b1;
    step(0, 0, 1, 1, 1, 16'h0);
    bus.sys_ack = 1'b0;
    step(0, 1, 1, 1, 1, 16'h0);

    // Contention guard: oe_n high in RD_LO keeps the pins released
    push(EV_RD, 16'h0044, 32'h0, 1);
    step(1, 0, 0, 1, 1, 16'h0044);
    step(1, 0, 1, 1, 0, 16'h0);
    bus.sys_ack = 1'b1; bus.sys_rdata = 32'h00005555;
    step(0, 0, 1, 1, 1, 16'h0);
    bus.sys_ack = 1'b0;
    chk("cont_da_t", 32'(bus.da_t), 32'd1);
    chk("cont_da_di", 32'(bus.da_di), 32'h5555);
    step(0, 0, 1, 1, 1, 16'h0);
    chk("cont_da_t2", 32'(bus.da_t), 32'd1);
    push(EV_PIN, 16'h0, 32'h00005555, 0);
    push(EV_PIN, 16'h0, 32'h00000000, 0);
    step(0, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    step(0, 1, 1, 1, 1, 16'h0);

    // Reset in WR_HI: everything back to reset values, no request follows
    step(1, 0, 0, 1, 1, 16'h0055);
    step(1, 0, 1, 0, 1, 16'h1111);
    rst = 1'b1;
    step(1, 0, 1, 0, 1, 16'h2222);
    chk_reset("rst1");
    rst = 1'b0;
    step(0, 0, 1, 1, 1, 16'h0);
    step(0, 0, 1, 1, 1, 16'h0);
    step(0, 1, 1, 1, 1, 16'h0);

`ifdef EIM_DA_TIMEOUT_EN
    // Read with no ack: error pulse after 8 cycles, dead word on the pins
    push(EV_RD, 16'h0077, 32'h0, 8);
    push(EV_ERR, 16'h0, 32'h0, 0);
    push(EV_PIN, 16'h0, 32'h0000BEEF, 0);
    push(EV_PIN, 16'h0, 32'h0000DEAD, 0);
    step(1, 0, 0, 1, 1, 16'h0077);
    step(1, 0, 1, 1, 0, 16'h0);
    repeat (8) step(0, 0, 1, 1, 0, 16'h0);
    step(0, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    step(1, 0, 1, 1, 0, 16'h0);
    step(0, 1, 1, 1, 1, 16'h0);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
